// File: rtl/led_panel_arbiter_if.sv
// Requester-side bundle for the LED panel arbiter: per-requester valid, pattern and grant ack.
interface led_panel_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_pattern;
    logic [NREQ-1:0]   req_ack;

    modport master (output req_valid, output req_pattern, input req_ack);
    modport slave  (input req_valid, input req_pattern, output req_ack);
endinterface

// File: rtl/led_panel_arbiter.sv
// Shares the 8 user LEDs among NREQ status requesters; debounced DIP switches pick
// round-robin, manual, walking-one or raw-switch display.
module led_panel_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DWELL   = 200000000,
    parameter int unsigned DEB_CYC = 2000000
) (
    input  logic                 sys0_clk,
    input  logic                 sys0_rst,
    led_panel_arbiter_if.slave   req,
    input  logic [7:0]           usr_sw_i,
    output logic [7:0]           led,
    output logic [2:0]           owner,
    output logic                 owner_vld
);
    localparam int unsigned DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned DBW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    typedef enum logic {StIdle, StShow} state_e;

    logic [7:0]     sw_meta, sw_s, sw_prev, sw_db;
    logic [DBW-1:0] deb_cnt;

    state_e         state_q;
    logic [1:0]     mode_q;
    logic [2:0]     last_q;
    logic [DW-1:0]  dwell_q;
    logic [NREQ-1:0] ack_q;

    logic [1:0]     mode;
    logic [2:0]     sel;
    logic [7:0]     valid8;
    logic [7:0]     pat [8];
    logic           gnt_found;
    logic [2:0]     gnt_idx;
    logic [2:0]     cand;
    logic [7:0]     gnt_oh;

    assign mode   = sw_db[7:6];
    assign sel    = sw_db[2:0];
    // Zero-padded to 8 so an out-of-range manual select reads as not valid.
    assign valid8 = 8'(req.req_valid);
    assign gnt_oh = 8'b1 << gnt_idx;
    assign req.req_ack = ack_q;

    for (genvar g = 0; g < 8; g++) begin : g_pat
        if (g < NREQ) begin : g_on
            assign pat[g] = req.req_pattern[8*g +: 8];
        end else begin : g_off
            assign pat[g] = 8'h00;
        end
    end

    // Search upward with wrap from the last grant; the last owner itself is checked last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 3'((32'(last_q) + 32'd1 + i) % NREQ);
            if (!gnt_found && valid8[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
            sw_prev <= '0;
            sw_db   <= '0;
            deb_cnt <= '0;
        end else begin
            sw_meta <= usr_sw_i;
            sw_s    <= sw_meta;
            sw_prev <= sw_s;
            if (sw_s != sw_prev) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DBW'(DEB_CYC - 1)) begin
                sw_db   <= sw_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            state_q   <= StIdle;
            mode_q    <= 2'b00;
            last_q    <= 3'(NREQ - 1);
            dwell_q   <= '0;
            ack_q     <= '0;
            led       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
        end else begin
            ack_q  <= '0;
            mode_q <= mode;
            if (mode != mode_q) begin
                state_q   <= StIdle;
                dwell_q   <= '0;
                led       <= '0;
                owner_vld <= 1'b0;
            end else begin
                unique case (mode)
                    2'b00: begin
                        unique case (state_q)
                            StIdle: begin
                                led       <= '0;
                                owner_vld <= 1'b0;
                                dwell_q   <= '0;
                                if (gnt_found) begin
                                    state_q   <= StShow;
                                    owner     <= gnt_idx;
                                    last_q    <= gnt_idx;
                                    ack_q     <= gnt_oh[NREQ-1:0];
                                    owner_vld <= 1'b1;
                                end
                            end
                            StShow: begin
                                led       <= pat[owner];
                                owner_vld <= 1'b1;
                                if (dwell_q == DW'(DWELL - 1) || !valid8[owner]) begin
                                    dwell_q <= '0;
                                    if (gnt_found) begin
                                        owner  <= gnt_idx;
                                        last_q <= gnt_idx;
                                        ack_q  <= gnt_oh[NREQ-1:0];
                                    end else begin
                                        state_q   <= StIdle;
                                        led       <= '0;
                                        owner_vld <= 1'b0;
                                    end
                                end else begin
                                    dwell_q <= dwell_q + DW'(1);
                                end
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                    2'b01: begin
                        if (valid8[sel]) begin
                            led       <= pat[sel];
                            owner     <= sel;
                            owner_vld <= 1'b1;
                        end else begin
                            led       <= '0;
                            owner_vld <= 1'b0;
                        end
                    end
                    2'b10: begin
                        owner_vld <= 1'b0;
                        // led is only zero here on the first cycle after entering walk.
                        if (led == 8'h00) begin
                            led     <= 8'h01;
                            dwell_q <= '0;
                        end else if (dwell_q == DW'(DWELL - 1)) begin
                            led     <= {led[6:0], led[7]};
                            dwell_q <= '0;
                        end else begin
                            dwell_q <= dwell_q + DW'(1);
                        end
                    end
                    2'b11: begin
                        led       <= sw_db;
                        owner_vld <= 1'b0;
                    end
                    default: led <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_panel_arbiter.sv
// Directed bench for led_panel_arbiter with DWELL=8, DEB_CYC=4.
module tb_led_panel_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'h00;
    logic [7:0] led;
    logic [2:0] owner;
    logic       owner_vld;
    int         checks = 0;
    int         errors = 0;

    led_panel_arbiter_if #(.NREQ(4)) bus ();

    led_panel_arbiter #(.NREQ(4), .DWELL(8), .DEB_CYC(4)) dut (
        .sys0_clk  (clk),
        .sys0_rst  (rst),
        .req       (bus),
        .usr_sw_i  (sw),
        .led       (led),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rr_own [3];
        logic [7:0] rr_led [3];
        logic [7:0] walk;
        rr_own = '{3'd1, 3'd3, 3'd0};
        rr_led = '{8'hA1, 8'hA3, 8'hA0};

        bus.req_valid   = 4'b1011;
        bus.req_pattern = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick(2);
        check("rst_led", 32'(led), 32'h00);
        check("rst_vld", 32'(owner_vld), 32'h0);
        check("rst_ack", 32'(bus.req_ack), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);

        // Round-robin over 1011: first grant is 0.
        rst = 1'b0;
        tick(1);
        check("rr0_owner", 32'(owner), 32'h0);
        check("rr0_ack", 32'(bus.req_ack), 32'h1);
        check("rr0_vld", 32'(owner_vld), 32'h1);
        check("rr0_led_lat", 32'(led), 32'h00);
        tick(1);
        check("rr0_led", 32'(led), 32'hA0);
        check("rr0_ack_end", 32'(bus.req_ack), 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick(7);
            check("rr_owner", 32'(owner), 32'(rr_own[s]));
            check("rr_ack", 32'(bus.req_ack), 32'(4'b0001 << rr_own[s]));
            tick(1);
            check("rr_led", 32'(led), 32'(rr_led[s]));
            check("rr_ack_end", 32'(bus.req_ack), 32'h0);
        end

        // Req 1 slot, then early drop 3 cycles in.
        tick(7);
        check("drop_own1", 32'(owner), 32'h1);
        check("drop_ack1", 32'(bus.req_ack), 32'h2);
        tick(3);
        bus.req_valid = 4'b1001;
        tick(1);
        check("drop_owner", 32'(owner), 32'h3);
        check("drop_ack", 32'(bus.req_ack), 32'h8);
        check("drop_led_old", 32'(led), 32'hA1);
        tick(1);
        check("drop_led", 32'(led), 32'hA3);

        // Asynchronous reset mid-slot.
        #3 rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'h00);
        check("arst_vld", 32'(owner_vld), 32'h0);
        check("arst_ack", 32'(bus.req_ack), 32'h0);
        bus.req_valid = 4'b1011;
        tick(2);
        check("arst_hold_ack", 32'(bus.req_ack), 32'h0);
        rst = 1'b0;
        tick(1);
        check("arst_gnt_owner", 32'(owner), 32'h0);
        check("arst_gnt_ack", 32'(bus.req_ack), 32'h1);
        tick(1);
        check("arst_gnt_led", 32'(led), 32'hA0);

        // Three-cycle switch glitch must not reach sw_db.
        sw = 8'h80;
        tick(3);
        sw = 8'h00;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            check("glitch_vld", 32'(owner_vld), 32'h1);
        end
        check("glitch_swdb", 32'(dut.sw_db), 32'h00);

        // Manual mode.
        sw = 8'h41;
        tick(12);
        check("man1_led", 32'(led), 32'hA1);
        check("man1_owner", 32'(owner), 32'h1);
        check("man1_vld", 32'(owner_vld), 32'h1);
        check("man1_ack", 32'(bus.req_ack), 32'h0);
        sw = 8'h42;
        tick(10);
        check("man2_led", 32'(led), 32'h00);
        check("man2_vld", 32'(owner_vld), 32'h0);
        sw = 8'h43;
        tick(10);
        check("man3_led", 32'(led), 32'hA3);
        check("man3_owner", 32'(owner), 32'h3);
        sw = 8'h47;
        tick(10);
        check("man7_led", 32'(led), 32'h00);
        check("man7_vld", 32'(owner_vld), 32'h0);

        // Walk mode: entry at 01, rotate every 8 cycles, wrap to 01.
        sw = 8'h80;
        tick(8);
        check("walk_chg_led", 32'(led), 32'h00);
        tick(1);
        check("walk_start", 32'(led), 32'h01);
        check("walk_vld", 32'(owner_vld), 32'h0);
        walk = 8'h01;
        for (int k = 0; k < 8; k++) begin
            walk = {walk[6:0], walk[7]};
            tick(8);
            check("walk_step", 32'(led), 32'(walk));
        end

        // Raw mode.
        sw = 8'hC5;
        tick(9);
        check("raw_led", 32'(led), 32'hC5);
        check("raw_vld", 32'(owner_vld), 32'h0);

        // Sole requester re-granted each slot.
        sw = 8'h00;
        bus.req_valid = 4'b0100;
        tick(9);
        check("sole_owner", 32'(owner), 32'h2);
        check("sole_ack", 32'(bus.req_ack), 32'h4);
        check("sole_vld", 32'(owner_vld), 32'h1);
        tick(1);
        check("sole_led", 32'(led), 32'hA2);
        check("sole_ack_end", 32'(bus.req_ack), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick(7);
            check("sole_regrant_ack", 32'(bus.req_ack), 32'h4);
            check("sole_regrant_owner", 32'(owner), 32'h2);
            check("sole_regrant_led", 32'(led), 32'hA2);
            tick(1);
            check("sole_regrant_ack_end", 32'(bus.req_ack), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
